// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings common to the transmitter and the future receiver,
// and the default frame timing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Producer-side valid/ready word handshake into the UART transmitter.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
// Bit-period counter: pulses o_bit_done on the last clk of each serial bit.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_bit_done
);
    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign o_bit_done = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, stop bit; tx, tx_ready and
// busy are all registered.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_serializer_if.slave  bus,
    output logic                 tx,
    output logic                 busy
);
    localparam int BCW = $clog2(DATA_BITS + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be 2 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("DATA_BITS must be in 5..9");
    end

    uart_state_e          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [BCW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 w_accept;
    logic                 w_bit_done;
    logic                 w_baud_clr;

    assign w_accept   = bus.tx_valid && r_ready;
    // Holding the counter clear through IDLE also covers the clear on handshake.
    assign w_baud_clr = (r_state == IDLE);

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_baud_clr),
        .o_bit_done (w_bit_done)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tx_nxt      = r_tx;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt   = START;
                    w_shift_nxt   = bus.tx_data;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = 1'b0;
                end
            end
            START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_done) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_done) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                    if (r_bit_cnt == BCW'(DATA_BITS - 1)) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // Next bit is presented on the same edge as the shift.
                        w_tx_nxt = r_shift[1];
                    end
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_done)
                    w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
            r_ready   <= (w_state_nxt == IDLE);
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign bus.tx_ready = r_ready;
    assign tx           = r_tx;
    assign busy         = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Drives directed and random traffic into uart_tx_serializer and compares every cycle
// against a frame-timeline model of the serial line.
module tb_uart_tx_serializer;
    localparam int CPB       = 4;
    localparam int DB        = 8;
    localparam int FRAME_LEN = (DB + 2) * CPB;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic busy;

    uart_tx_serializer_if #(.DATA_BITS(DB)) u_if ();

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: a frame is either absent or at cycle m_pos of FRAME_LEN for word m_word.
    logic          m_busy = 1'b0;
    int            m_pos  = 0;
    logic [DB-1:0] m_word = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int idx;
        if (!m_busy) return 1'b1;
        idx = m_pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= DB) return m_word[idx-1];
        return 1'b1;
    endfunction

    task automatic step(input logic r, input logic v, input logic [DB-1:0] d);
        reset       = r;
        u_if.tx_valid = v;
        u_if.tx_data  = d;
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (v) begin
                m_busy = 1'b1;
                m_pos  = 0;
                m_word = d;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME_LEN) m_busy = 1'b0;
        end
        #1;
        chk("tx",       32'(tx),            32'(exp_tx()));
        chk("tx_ready", 32'(u_if.tx_ready), 32'(!m_busy));
        chk("busy",     32'(busy),          32'(m_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, DB'($urandom));
    endtask

    initial begin
        logic [9:0] seq;
        int         rdy_low;

        reset = 1'b1;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = '0;

        // Reset and idle line
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        idle(10);

        // Single 0xA5 frame, mid-bit samples and ready-low length
        seq = '0;
        rdy_low = 0;
        step(1'b0, 1'b1, 8'hA5);
        if (!u_if.tx_ready) rdy_low++;
        for (int i = 1; i < FRAME_LEN + 5; i++) begin
            if (i % CPB == 2) seq[i/CPB] = tx;
            step(1'b0, 1'b0, 8'h00);
            if (!u_if.tx_ready) rdy_low++;
        end
        chk("a5_bits", 32'(seq), 32'(10'b1101001010));
        chk("a5_ready_low", 32'(rdy_low), 32'(FRAME_LEN));

        // Data changes after acceptance are ignored
        step(1'b0, 1'b1, 8'h3C);
        for (int i = 1; i < FRAME_LEN + 2; i++) step(1'b0, 1'b0, 8'hFF);

        // Back-to-back with valid held: one idle cycle between frames
        step(1'b0, 1'b1, 8'h01);
        for (int i = 1; i <= FRAME_LEN + 1; i++) step(1'b0, 1'b1, 8'h80);
        idle(FRAME_LEN + 2);

        // Reset mid-frame, then a clean 0x55 frame
        step(1'b0, 1'b1, 8'h00);
        idle(14);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h55);
        idle(FRAME_LEN + 2);

        // Valid pulse while busy is dropped
        step(1'b0, 1'b1, 8'h0F);
        idle(15);
        step(1'b0, 1'b1, 8'hFF);
        idle(FRAME_LEN + 2);

        // Reset wins over a simultaneous valid
        step(1'b1, 1'b1, 8'hAA);
        idle(3);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, DB'($urandom));
        idle(FRAME_LEN + 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-wide UART-style serial transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on one line.
- Frame format: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
- Transmit end of the serial link; the matching receiver samples `tx` on the far side.
- Sits between the register/control logic and the board pin; `tx` is fully registered.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Legal range is 2 or more; a smaller value is a synthesis-time error.
- DATA_BITS, 8: payload width per frame. Legal range is 5..9.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  payload word; sampled only on handshake.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  high from acceptance through the last stop-bit cycle.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: state=IDLE, tx=1, tx_ready=1, busy=0. The shift register and both counters clear to 0.
- Reset mid-frame: on the next edge the frame is abandoned, tx=1 and state=IDLE. No partial stop bit is sent.
- Handshake:
  - Transfer occurs when tx_valid=1 and tx_ready=1 at a rising edge.
  - tx_ready is 1 only in IDLE. It is a registered state decode and does not depend combinationally on tx_valid.
  - tx_data is latched into the shift register at acceptance. Later changes to tx_data are ignored.
  - tx_valid while busy is ignored. The producer must hold it; no word is queued.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. On handshake, go to START, bit_cnt=0, baud_cnt=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit.
    - At each bit end, shift right and increment bit_cnt.
    - After bit DATA_BITS-1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - tx drops to 0 on the edge that registers the handshake, i.e. the first START cycle.
  - Frame length is exactly (DATA_BITS+2)*CLKS_PER_BIT cycles.
  - tx_ready returns to 1 in the cycle after the last STOP cycle.
  - Back-to-back frames are therefore separated by exactly one IDLE cycle (tx=1). Minimum period is (DATA_BITS+2)*CLKS_PER_BIT+1 cycles.
- Counter widths:
  - baud_cnt is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1.
  - bit_cnt is $clog2(DATA_BITS+1) bits.
- busy = (state != IDLE), registered.
- Simultaneous reset and tx_valid: reset wins and the word is not accepted.

Decomposition:
- Shared package/include `uart_pkg` holds:
  - the 2-bit state encodings IDLE=0, START=1, DATA=2, STOP=3, shared with the future receiver;
  - the default CLKS_PER_BIT and DATA_BITS constants.
- One natural sub-module, `baud_tick_gen`: the CLKS_PER_BIT counter.
  - It has a synchronous clear input and emits a one-cycle `bit_done` pulse on count CLKS_PER_BIT-1.
  - The parent clears it on handshake.

Test Plan:
- Idle check (CLKS_PER_BIT=4, DATA_BITS=8): reset for 2 cycles, then 10 idle cycles -> tx=1, tx_ready=1, busy=0 throughout.
- Single frame: send 0xA5 -> tx holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles (40 cycles total). tx_ready=0 for those 40 cycles, then 1.
- Data-hold independence: accept 0x3C, then drive tx_data=0xFF at the next edge -> serial bits remain 0,0,0,1,1,1,1,0,0.
- Back-to-back: tx_valid held high with 0x01 then 0x80 -> exactly one tx=1 idle cycle between the stop bit of the first frame and the start bit of the second. Second frame data bits are 0,0,0,0,0,0,0,1.
- Reset mid-frame: assert reset at cycle 15 of a 0x00 frame -> on the next edge tx=1, tx_ready=1, busy=0. A new 0x55 sent afterwards is a clean, full 40-cycle frame.
- Busy-ignore: pulse tx_valid with 0xFF during DATA of a 0x0F frame -> the 0xFF is never transmitted and the 0x0F frame completes unaltered.
